surf_cmd_receiver: RTL and testbench

SURF-side receiver for the TURF serial command line (one CMD pair per SURF). It deserializes framed event-ID commands, checks framing and parity, and presents buffer number plus event ID through a valid/ack handshake to SURF readout logic. It is the far end of the TURF trigger interface's CMD output, clocked by the SURF clock that the TURF forwards alongside it.

---
 rtl/surf_cmd_pkg.sv | 28 ++
 rtl/surf_cmd_errcnt.sv | 43 ++++
 rtl/surf_cmd_receiver.sv | 164 ++++++++++++++++
 tb/tb_surf_cmd_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : surf_cmd_pkg
//  Description : Shared types and constants for the SURF CMD-line receiver:
//                FSM state enum, start/stop bit values, frame length helper
//                and error-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package surf_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        SHIFT    = 2'd2,
        STOP     = 2'd3
    } state_e;

    localparam logic START_BIT    = 1'b1;
    localparam logic STOP_BIT     = 1'b0;
    localparam int   ERRCNT_WIDTH = 16;

    // Start + buffer + evid + parity + stop
    function automatic int frame_len(input int buf_bits, input int evid_bits);
        return buf_bits + evid_bits + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/surf_cmd_errcnt.sv
`default_nettype none
// ============================================================================
//  Module      : surf_cmd_errcnt
//  Description : Saturating error counter with synchronous clear. Clear has
//                priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module surf_cmd_errcnt
    import surf_cmd_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    inc_i,
    output logic [ERRCNT_WIDTH-1:0] count_o
);

    logic [ERRCNT_WIDTH-1:0] count_q;
    logic [ERRCNT_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment until all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/surf_cmd_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : surf_cmd_receiver
//  Description : Deserializes framed TURF CMD commands (start, buffer, evid,
//                even parity, stop), flags framing/parity/overrun events and
//                presents buffer/evid through a valid/ack handshake.
//                Optional error counter enabled by SURF_CMD_ERRCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module surf_cmd_receiver
    import surf_cmd_pkg::*;
#(
    parameter int BUF_BITS  = 2,
    parameter int EVID_BITS = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_i,
    input  logic                    ack_i,
    input  logic                    cnt_clr_i,
    output logic                    valid_o,
    output logic [BUF_BITS-1:0]     buffer_o,
    output logic [EVID_BITS-1:0]    evid_o,
    output logic                    perr_o,
    output logic                    ferr_o,
    output logic                    overrun_o,
    output logic [ERRCNT_WIDTH-1:0] err_count_o
);

    // Bits shifted in SHIFT: buffer, evid and parity
    localparam int         C_SHIFT_W  = frame_len(BUF_BITS, EVID_BITS) - 2;
    localparam logic [5:0] C_LAST_BIT = 6'(C_SHIFT_W - 1);

    logic                 cmd_q;
    // Low after reset: the reset value of cmd_q is not a real line sample,
    // so WAIT_LOW must not treat it as the low it is waiting for.
    logic                 sample_ok_q;
    state_e               state_q,   state_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    logic                 par_q,     par_d;
    logic [C_SHIFT_W-1:0] shreg_q,   shreg_d;
    logic                 valid_q,   valid_d;
    logic [BUF_BITS-1:0]  buffer_q,  buffer_d;
    logic [EVID_BITS-1:0] evid_q,    evid_d;
    logic                 perr_q,    perr_d;
    logic                 ferr_q,    ferr_d;
    logic                 overrun_q, overrun_d;

    // Frame FSM, shifter, parity accumulator and output handshake
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        shreg_d   = shreg_q;
        valid_d   = valid_q;
        buffer_d  = buffer_q;
        evid_d    = evid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        overrun_d = 1'b0;

        if (ack_i && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            WAIT_LOW: begin
                if (sample_ok_q && (cmd_q == 1'b0)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cmd_q == START_BIT) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[C_SHIFT_W-2:0], cmd_q};
                par_d   = par_q ^ cmd_q;
                if (bit_cnt_q == C_LAST_BIT) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            STOP: begin
                if (cmd_q == STOP_BIT) begin
                    state_d = IDLE;
                    if (par_q != 1'b0) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || ack_i) begin
                        valid_d  = 1'b1;
                        buffer_d = shreg_q[C_SHIFT_W-1 -: BUF_BITS];
                        evid_d   = shreg_q[EVID_BITS:1];
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q       <= 1'b0;
            sample_ok_q <= 1'b0;
            state_q     <= WAIT_LOW;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            shreg_q     <= '0;
            valid_q     <= 1'b0;
            buffer_q    <= '0;
            evid_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cmd_q       <= cmd_i;
            sample_ok_q <= 1'b1;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            shreg_q     <= shreg_d;
            valid_q     <= valid_d;
            buffer_q    <= buffer_d;
            evid_q      <= evid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign buffer_o  = buffer_q;
    assign evid_o    = evid_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign overrun_o = overrun_q;

`ifdef SURF_CMD_ERRCNT_EN
    // Increment on the same cycle the error pulse registers, so the count
    // and the pulse become visible together.
    surf_cmd_errcnt u_errcnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (perr_d | ferr_d),
        .count_o (err_count_o)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign err_count_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_surf_cmd_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_surf_cmd_receiver
//  Description : Directed self-checking bench for surf_cmd_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_surf_cmd_receiver;

`ifdef SURF_CMD_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        cnt_clr_i = 1'b0;
    logic        valid_o;
    logic [1:0]  buffer_o;
    logic [31:0] evid_o;
    logic        perr_o;
    logic        ferr_o;
    logic        overrun_o;
    logic [15:0] err_count_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    surf_cmd_receiver #(.BUF_BITS(2), .EVID_BITS(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_i       (cmd_i),
        .ack_i       (ack_i),
        .cnt_clr_i   (cnt_clr_i),
        .valid_o     (valid_o),
        .buffer_o    (buffer_o),
        .evid_o      (evid_o),
        .perr_o      (perr_o),
        .ferr_o      (ferr_o),
        .overrun_o   (overrun_o),
        .err_count_o (err_count_o)
    );

`ifdef SURF_CMD_ERRCNT_EN
    logic        u_clr = 1'b0;
    logic        u_inc = 1'b0;
    logic [15:0] u_count;
    surf_cmd_errcnt u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (u_clr),
        .inc_i   (u_inc),
        .count_o (u_count)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        cmd_i = b;
        tick();
    endtask

    function automatic logic [36:0] make_frame(input logic [1:0] b, input logic [31:0] e,
                                               input logic pflip, input logic stop);
        logic par;
        par = (^{b, e}) ^ pflip;
        return {1'b1, b, e, par, stop};
    endfunction

    // Start bit in cycle t; returns in cycle t+37 with cmd_i still at the stop value
    task automatic send_frame(input logic [1:0] b, input logic [31:0] e,
                              input logic pflip, input logic stop);
        logic [36:0] f;
        f = make_frame(b, e, pflip, stop);
        for (int i = 36; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic ack_pulse();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    logic [36:0] part;
    logic        bad;

    initial begin
        // Reset
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_buffer", buffer_o, 0);
        chk("rst_evid", evid_o, 0);
        chk("rst_pulses", {perr_o, ferr_o, overrun_o}, 0);
        chk("rst_errcnt", err_count_o, 0);
        rst_i = 1'b0;
        repeat (3) tick();

        // Good frame with latency check
        send_frame(2'b10, 32'h0000_1234, 1'b0, 1'b0);
        chk("lat_early_valid", valid_o, 0);
        cmd_i = 1'b0;
        tick();
        chk("good_valid", valid_o, 1);
        chk("good_buffer", buffer_o, 2);
        chk("good_evid", evid_o, 32'h0000_1234);
        chk("good_no_err", {perr_o, ferr_o, overrun_o}, 0);
        ack_pulse();
        chk("ack_clears", valid_o, 0);

        // Parity error
        send_frame(2'b10, 32'h0000_1234, 1'b1, 1'b0);
        cmd_i = 1'b0;
        tick();
        chk("perr_pulse", perr_o, 1);
        chk("perr_valid", valid_o, 0);
        chk("perr_count", err_count_o, ERRCNT_ON ? 64'd1 : 64'd0);
        tick();
        chk("perr_one_cycle", perr_o, 0);

        // Framing error, line held high, then a good frame
        send_frame(2'b01, 32'h1111_2222, 1'b0, 1'b1);
        cmd_i = 1'b1;
        tick();
        chk("ferr_pulse", ferr_o, 1);
        chk("ferr_no_perr", perr_o, 0);
        bad = 1'b0;
        repeat (4) begin
            tick();
            bad = bad | ferr_o | valid_o | perr_o;
        end
        chk("ferr_quiet_high", bad, 0);
        chk("ferr_count", err_count_o, ERRCNT_ON ? 64'd2 : 64'd0);
        cmd_i = 1'b0;
        repeat (2) tick();
        send_frame(2'b01, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cmd_i = 1'b0;
        tick();
        chk("after_ferr_valid", valid_o, 1);
        chk("after_ferr_evid", evid_o, 32'hDEAD_BEEF);
        ack_pulse();

        // Back-to-back, no ack: overrun
        send_frame(2'b00, 32'd1, 1'b0, 1'b0);
        send_frame(2'b11, 32'd2, 1'b0, 1'b0);
        cmd_i = 1'b0;
        tick();
        chk("ovr_pulse", overrun_o, 1);
        chk("ovr_evid_kept", evid_o, 1);
        chk("ovr_buffer_kept", buffer_o, 0);
        chk("ovr_valid", valid_o, 1);
        tick();
        chk("ovr_one_cycle", overrun_o, 0);
        ack_pulse();
        chk("ovr_ack", valid_o, 0);

        // Back-to-back with ack in the load cycle
        send_frame(2'b00, 32'd1, 1'b0, 1'b0);
        send_frame(2'b11, 32'd2, 1'b0, 1'b0);
        cmd_i = 1'b0;
        ack_pulse();
        chk("ackld_evid", evid_o, 2);
        chk("ackld_buffer", buffer_o, 3);
        chk("ackld_no_ovr", overrun_o, 0);
        tick();
        chk("ackld_valid_held", valid_o, 1);

        // Reset at bit 20 with line left high (valid still set from above)
        part = make_frame(2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 36; i >= 16; i--) send_bit(part[i]);
        cmd_i = 1'b1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_outputs", {valid_o, buffer_o, evid_o}, 0);
        chk("midrst_errcnt", err_count_o, 0);
        bad = 1'b0;
        repeat (45) begin
            tick();
            bad = bad | valid_o | ferr_o | perr_o | overrun_o;
        end
        cmd_i = 1'b0;
        repeat (3) begin
            tick();
            bad = bad | valid_o | ferr_o | perr_o | overrun_o;
        end
        chk("midrst_remnant", bad, 0);
        send_frame(2'b01, 32'hA5A5_0F0F, 1'b0, 1'b0);
        cmd_i = 1'b0;
        tick();
        chk("midrst_next_valid", valid_o, 1);
        chk("midrst_next_data", {buffer_o, evid_o}, {2'b01, 32'hA5A5_0F0F});
        ack_pulse();

        // Counter clear coincident with an error
        send_frame(2'b00, 32'h0000_0007, 1'b1, 1'b0);
        cmd_i = 1'b0;
        tick();
        chk("cnt_one", err_count_o, ERRCNT_ON ? 64'd1 : 64'd0);
        send_frame(2'b00, 32'h0000_0007, 1'b1, 1'b0);
        cmd_i = 1'b0;
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        chk("cnt_clr_wins_perr", perr_o, 1);
        chk("cnt_clr_wins", err_count_o, 0);

`ifdef SURF_CMD_ERRCNT_EN
        // Saturation on the counter itself
        u_inc = 1'b1;
        repeat (65540) tick();
        chk("cnt_saturate", u_count, 16'hFFFF);
        u_clr = 1'b1;
        tick();
        u_clr = 1'b0;
        u_inc = 1'b0;
        chk("cnt_sat_clr", u_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
